// File: rtl/serial_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : serial_byte_assembler
// Purpose  : Collects a serial bit stream into WIDTH-bit words. Each word is
//            presented in a one-word holding register on a descending view
//            (pout) and an ascending view (pout_asc). Valid/ready on both
//            sides. sync re-aligns the word boundary and flags a dropped word.
// Revision : 1.0 - initial release
// ============================================================================
module serial_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sin,
  input  logic               sin_valid,
  output logic               sin_ready,
  input  logic               sync,
  output logic [WIDTH-1:0]   pout,
  output logic [0:WIDTH-1]   pout_asc,
  output logic               pout_valid,
  input  logic               pout_ready,
  output logic               dropped
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  // The only "state" is whether the final bit of a word is blocked by a full
  // holding register; it is fully decoded from cnt/pout_valid/pout_ready.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_dropped;

  logic [WIDTH-1:0] w_sh_shift;
  logic [WIDTH-1:0] w_sh_next;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_pout_next;
  logic             w_pout_valid_next;
  logic             w_dropped_next;
  logic             w_acc;
  state_t           w_state;

  // Bit-order selection: where the newly accepted bit enters the shifter.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sh_shift = {r_sh[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_sh_shift = {sin, r_sh[WIDTH-1:1]};
    end
  endgenerate

  // State decode and handshake: sync always gets through so re-alignment
  // can never be blocked by a stalled word.
  always_comb begin
    w_state = COLLECT;
    if ((r_cnt == C_LAST) && r_pout_valid && !pout_ready) begin
      w_state = STALL;
    end
    sin_ready = sync | (w_state == COLLECT);
    w_acc     = sin_valid & sin_ready;
  end

  // Next-state logic for the shifter, bit counter and holding register.
  always_comb begin
    w_sh_next         = r_sh;
    w_cnt_next        = r_cnt;
    w_pout_next       = r_pout;
    w_pout_valid_next = r_pout_valid & ~pout_ready;
    w_dropped_next    = 1'b0;
    if (sync) begin
      w_dropped_next = (r_cnt != '0);
      if (w_acc) begin
        w_sh_next  = w_sh_shift;
        w_cnt_next = CW'(1);
      end else begin
        w_cnt_next = '0;
      end
    end else if (w_acc) begin
      w_sh_next = w_sh_shift;
      if (r_cnt == C_LAST) begin
        // Completion is only reachable when the holding register is free or
        // draining this cycle, so the old word is never overwritten.
        w_cnt_next        = '0;
        w_pout_next       = w_sh_shift;
        w_pout_valid_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh         <= '0;
      r_cnt        <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_sh         <= w_sh_next;
      r_cnt        <= w_cnt_next;
      r_pout       <= w_pout_next;
      r_pout_valid <= w_pout_valid_next;
      r_dropped    <= w_dropped_next;
    end
  end

  assign pout       = r_pout;
  assign pout_asc   = r_pout;   // MSB-to-MSB: pout_asc[0] == pout[WIDTH-1]
  assign pout_valid = r_pout_valid;
  assign dropped    = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_byte_assembler
// Purpose  : Scoreboard bench. Two instances (MSB-first and LSB-first) share
//            one stimulus stream; a word-level reference model predicts the
//            handshake and pushes expected words, a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_byte_assembler;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic sync = 1'b0;
  logic pout_ready = 1'b0;

  logic         sr_m, pv_m, dr_m;
  logic [W-1:0] po_m;
  logic [0:W-1] pa_m;
  logic         sr_l, pv_l, dr_l;
  logic [W-1:0] po_l;
  logic [0:W-1] pa_l;

  int total = 0;
  int bad   = 0;

  // Reference model state: bits of the word in progress, expected words,
  // and whether the holding register is occupied.
  bit           bits[$];
  logic [W-1:0] qm[$];
  logic [W-1:0] ql[$];
  logic         m_full = 1'b0;
  logic         m_drop = 1'b0;

  always #5 clk = ~clk;

  serial_byte_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(sr_m),
    .sync(sync), .pout(po_m), .pout_asc(pa_m), .pout_valid(pv_m),
    .pout_ready(pout_ready), .dropped(dr_m)
  );

  serial_byte_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(sr_l),
    .sync(sync), .pout(po_l), .pout_asc(pa_l), .pout_valid(pv_l),
    .pout_ready(pout_ready), .dropped(dr_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, apply inputs, check the
  // combinational ready, then advance the model to the next edge.
  task automatic cyc(input logic r, input logic s, input logic v, input logic y, input logic p);
    logic         rdy;
    logic [W-1:0] wm, wl;
    @(posedge clk);
    #1;
    check("pout_valid_msb", pv_m, m_full);
    check("pout_valid_lsb", pv_l, m_full);
    check("dropped_msb", dr_m, m_drop);
    check("dropped_lsb", dr_l, m_drop);
    rst = r; sin = s; sin_valid = v; sync = y; pout_ready = p;
    #1;
    if (r) begin
      bits.delete(); qm.delete(); ql.delete();
      m_full = 1'b0;
      m_drop = 1'b0;
    end else begin
      rdy = y | !((bits.size() == W - 1) && m_full && !p);
      check("sin_ready_msb", sr_m, rdy);
      check("sin_ready_lsb", sr_l, rdy);
      m_drop = y && (bits.size() != 0);
      m_full = m_full && !p;
      if (y) begin
        bits.delete();
        if (v) bits.push_back(s);
      end else if (v && rdy) begin
        bits.push_back(s);
        if (bits.size() == W) begin
          wm = '0; wl = '0;
          for (int i = 0; i < W; i++) begin
            wm = wm + (W'(bits[i]) << (W - 1 - i));
            wl = wl + (W'(bits[i]) << i);
          end
          qm.push_back(wm);
          ql.push_back(wl);
          m_full = 1'b1;
          bits.delete();
        end
      end
    end
  endtask

  // Send n bits of val, first bit val[7], one bit per cycle.
  task automatic send(input logic [7:0] val, input int n, input logic p);
    logic [7:0] v;
    v = val;
    for (int i = 0; i < n; i++) cyc(1'b0, v[7 - i], 1'b1, 1'b0, p);
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, p);
  endtask

  // Monitor: whenever a word is presented it must match the queue head; it
  // is retired when the downstream takes it.
  always @(negedge clk) begin
    logic [0:W-1] ea;
    if (!rst && pv_m === 1'b1) begin
      if (qm.size() == 0) begin
        total++; bad++;
        $display("FAIL pout_msb: got %0h expected no word at %0t", po_m, $time);
      end else begin
        for (int i = 0; i < W; i++) ea[i] = qm[0][W - 1 - i];
        check("pout_msb", po_m, qm[0]);
        check("pout_asc_msb", pa_m, ea);
        if (pout_ready) void'(qm.pop_front());
      end
    end
    if (!rst && pv_l === 1'b1) begin
      if (ql.size() == 0) begin
        total++; bad++;
        $display("FAIL pout_lsb: got %0h expected no word at %0t", po_l, $time);
      end else begin
        for (int i = 0; i < W; i++) ea[i] = ql[0][W - 1 - i];
        check("pout_lsb", po_l, ql[0]);
        check("pout_asc_lsb", pa_l, ea);
        if (pout_ready) void'(ql.pop_front());
      end
    end
  end

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Ordering patterns: A5, 01 (MSB-first view) and 80 stream (01 LSB-first).
    send(8'hA5, 8, 1'b1); idle(3, 1'b1);
    send(8'h01, 8, 1'b1); idle(3, 1'b1);
    send(8'h80, 8, 1'b1); idle(3, 1'b1);
    // Backpressure: hold a word, then stall the last bit of the next one.
    send(8'h3C, 8, 1'b0);
    send(8'h5A, 7, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    // Resync after three bits; the new word starts on the sync bit.
    send(8'hE0, 3, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    send(8'h6A, 7, 1'b1);
    idle(3, 1'b1);
    // Sync with no bit, mid-word.
    send(8'hFF, 4, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h96, 8, 1'b1); idle(3, 1'b1);
    // Reset mid-word, then a clean word.
    send(8'hFF, 5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 8, 1'b1); idle(3, 1'b1);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 499) == 0), 1'($urandom),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6));
    end
    idle(20, 1'b1);
    check("drain_msb", qm.size(), 0);
    check("drain_lsb", ql.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
